// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - traffic lamp protocol monitor: phase decode, blink/length checks, mode detect
module traffic_light_monitor (
  input  logic       clock,
  input  logic       reset,
  input  logic       red,
  input  logic       amber,
  input  logic       green,
  output logic [1:0] phase,
  output logic       phase_done,
  output logic [9:0] phase_len,
  output logic       mode,
  output logic       mode_valid,
  output logic       err_pulse,
  output logic [3:0] err_status
);

  localparam logic [1:0] S_SYNC  = 2'd0;
  localparam logic [1:0] S_RED   = 2'd1;
  localparam logic [1:0] S_GREEN = 2'd2;
  localparam logic [1:0] S_AMBER = 2'd3;

  logic       r_red, r_amber, r_green;
  logic       r_red_d, r_amber_d, r_green_d;
  logic [1:0] r_state;
  logic       r_checked;
  logic [9:0] r_cnt;
  logic [1:0] r_low_cnt;
  logic [9:0] r_low1, r_low2;
  logic [9:0] r_red_len;
  logic       r_red_ok;
  logic       r_phase_done;
  logic [9:0] r_phase_len;
  logic       r_mode, r_mode_valid, r_err_pulse;
  logic [3:0] r_err_status;

  logic [2:0] w_lamps, w_prev, w_rise;
  logic       w_multi, w_dbl_low, w_single_rise;
  logic [1:0] w_rise_state, w_next_state;
  logic       w_active_on;
  logic [9:0] w_cnt_inc;
  logic       w_blink_bad, w_len_bad, w_close_err;

  assign w_lamps       = {r_green, r_amber, r_red};
  assign w_prev        = {r_green_d, r_amber_d, r_red_d};
  assign w_rise        = w_lamps & ~w_prev;
  assign w_multi       = (r_red & r_amber) | (r_red & r_green) | (r_amber & r_green);
  assign w_dbl_low     = (w_lamps == 3'b000) && (w_prev == 3'b000);
  assign w_single_rise = !w_multi && (w_rise != 3'b000) && (w_lamps == w_rise);
  assign w_cnt_inc     = (r_cnt == 10'd1023) ? 10'd1023 : r_cnt + 10'd1;

  always_comb begin
    w_rise_state = S_SYNC;
    if (w_rise[0])      w_rise_state = S_RED;
    else if (w_rise[1]) w_rise_state = S_AMBER;
    else if (w_rise[2]) w_rise_state = S_GREEN;
  end

  always_comb begin
    w_next_state = S_SYNC;
    w_active_on  = 1'b0;
    case (r_state)
      S_RED:   begin w_next_state = S_GREEN; w_active_on = r_red;   end
      S_GREEN: begin w_next_state = S_AMBER; w_active_on = r_green; end
      S_AMBER: begin w_next_state = S_RED;   w_active_on = r_amber; end
      default: begin w_next_state = S_SYNC;  w_active_on = 1'b0;    end
    endcase
  end

  // At close r_cnt holds L: the active lamp must have been low exactly at L-2 and L.
  assign w_blink_bad = !((r_low_cnt == 2'd2) && (r_low1 == r_cnt - 10'd2) && (r_low2 == r_cnt));
  assign w_len_bad   = (r_cnt == 10'd1023) ||
                       ((r_state == S_AMBER) ? (r_cnt != 10'd30)
                                             : ((r_cnt != 10'd350) && (r_cnt != 10'd200)));
  assign w_close_err = r_checked && (w_blink_bad || w_len_bad);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_red     <= 1'b0;
      r_amber   <= 1'b0;
      r_green   <= 1'b0;
      r_red_d   <= 1'b0;
      r_amber_d <= 1'b0;
      r_green_d <= 1'b0;
    end else begin
      r_red     <= red;
      r_amber   <= amber;
      r_green   <= green;
      r_red_d   <= r_red;
      r_amber_d <= r_amber;
      r_green_d <= r_green;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_SYNC;
      r_checked    <= 1'b0;
      r_cnt        <= 10'd0;
      r_low_cnt    <= 2'd0;
      r_low1       <= 10'd0;
      r_low2       <= 10'd0;
      r_red_len    <= 10'd0;
      r_red_ok     <= 1'b0;
      r_phase_done <= 1'b0;
      r_phase_len  <= 10'd0;
      r_mode       <= 1'b0;
      r_mode_valid <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_status <= 4'd0;
    end else begin
      r_phase_done <= 1'b0;
      r_err_pulse  <= 1'b0;
      if (r_state == S_SYNC) begin
        if (w_single_rise) begin
          r_state   <= w_rise_state;
          r_checked <= 1'b0;
          r_cnt     <= 10'd1;
          r_low_cnt <= 2'd0;
        end
      end else if (w_multi || w_dbl_low) begin
        r_err_status[1] <= r_err_status[1] | w_multi;
        r_err_status[2] <= r_err_status[2] | (w_dbl_low & !w_multi);
        r_err_pulse     <= 1'b1;
        r_mode_valid    <= 1'b0;
        r_state         <= S_SYNC;
        r_cnt           <= 10'd0;
        r_low_cnt       <= 2'd0;
      end else if (w_single_rise && (w_rise_state == w_next_state)) begin
        if (w_close_err) begin
          r_err_status[2] <= r_err_status[2] | w_blink_bad;
          r_err_status[3] <= r_err_status[3] | w_len_bad;
          r_err_pulse     <= 1'b1;
          r_mode_valid    <= 1'b0;
        end else if (r_checked) begin
          r_phase_done <= 1'b1;
          r_phase_len  <= r_cnt;
          if (r_state == S_GREEN) begin
            if (r_red_ok && (r_red_len == r_cnt)) begin
              r_mode       <= (r_cnt == 10'd200);
              r_mode_valid <= 1'b1;
            end else begin
              r_mode_valid <= 1'b0;
            end
          end
        end
        if (r_state == S_RED) begin
          r_red_ok  <= r_checked && !w_close_err;
          r_red_len <= r_cnt;
        end
        r_state   <= w_next_state;
        r_checked <= 1'b1;
        r_cnt     <= 10'd1;
        r_low_cnt <= 2'd0;
      end else if (w_single_rise && (w_rise_state != r_state)) begin
        r_err_status[0] <= 1'b1;
        r_err_pulse     <= 1'b1;
        r_mode_valid    <= 1'b0;
        r_state         <= w_rise_state;
        r_checked       <= 1'b0;
        r_cnt           <= 10'd1;
        r_low_cnt       <= 2'd0;
      end else begin
        r_cnt <= w_cnt_inc;
        if (!w_active_on) begin
          if (r_low_cnt == 2'd0) r_low1 <= w_cnt_inc;
          if (r_low_cnt == 2'd1) r_low2 <= w_cnt_inc;
          if (r_low_cnt != 2'd3) r_low_cnt <= r_low_cnt + 2'd1;
        end
      end
    end
  end

  assign phase      = r_state;
  assign phase_done = r_phase_done;
  assign phase_len  = r_phase_len;
  assign mode       = r_mode;
  assign mode_valid = r_mode_valid;
  assign err_pulse  = r_err_pulse;
  assign err_status = r_err_status;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed bench for traffic_light_monitor
module tb_traffic_light_monitor;

  logic       clock, reset, red, amber, green;
  logic [1:0] phase;
  logic       phase_done, mode, mode_valid, err_pulse;
  logic [9:0] phase_len;
  logic [3:0] err_status;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int errp_cnt = 0;

  typedef struct {
    int lamp;     // 1=RED 2=GREEN 3=AMBER
    int len;
    int variant;  // 0=legal blink, 1=single low at L only
    int e_phase;
    int e_done;
    int e_len;
    int e_err;
    int e_mv;
    int e_mode;
    int e_errp;
  } vec_t;

  vec_t tbl[13];

  traffic_light_monitor dut (
    .clock(clock), .reset(reset), .red(red), .amber(amber), .green(green),
    .phase(phase), .phase_done(phase_done), .phase_len(phase_len),
    .mode(mode), .mode_valid(mode_valid), .err_pulse(err_pulse), .err_status(err_status)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) begin
    if (reset) begin
      done_cnt = 0;
      errp_cnt = 0;
    end else begin
      if (phase_done) done_cnt = done_cnt + 1;
      if (err_pulse)  errp_cnt = errp_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic a, input logic g);
    @(negedge clock);
    red = r; amber = a; green = g;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_phase(input int lamp, input int len, input int variant);
    for (int p = 1; p <= len; p++) begin
      logic on;
      on = (variant == 0) ? !((p == len - 2) || (p == len)) : (p != len);
      step((lamp == 1) && on, (lamp == 3) && on, (lamp == 2) && on);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; red = 1'b0; amber = 1'b0; green = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_done"}, phase_done, 0);
    chk({tag, "_len"}, phase_len, 0);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_mv"}, mode_valid, 0);
    chk({tag, "_errp"}, err_pulse, 0);
    chk({tag, "_errst"}, err_status, 0);
  endtask

  initial begin
    tbl[0]  = '{3,  30, 0, 3, 0,   0,  0, 0, 0, 0};
    tbl[1]  = '{1, 350, 0, 1, 0,   0,  0, 0, 0, 0};
    tbl[2]  = '{2, 350, 0, 2, 1, 350,  0, 0, 0, 0};
    tbl[3]  = '{3,  30, 0, 3, 2, 350,  0, 1, 0, 0};
    tbl[4]  = '{1, 200, 0, 1, 3,  30,  0, 1, 0, 0};
    tbl[5]  = '{2, 200, 0, 2, 4, 200,  0, 1, 0, 0};
    tbl[6]  = '{3,  30, 0, 3, 5, 200,  0, 1, 1, 0};
    tbl[7]  = '{1, 200, 0, 1, 6,  30,  0, 1, 1, 0};
    tbl[8]  = '{2, 200, 1, 2, 7, 200,  0, 1, 1, 0};
    tbl[9]  = '{3,  30, 0, 3, 7, 200,  4, 0, 1, 1};
    tbl[10] = '{1, 201, 0, 1, 8,  30,  4, 0, 1, 1};
    tbl[11] = '{2, 200, 0, 2, 8,  30, 12, 0, 1, 2};
    tbl[12] = '{3,  30, 0, 3, 9, 200, 12, 0, 1, 2};

    reset = 1'b1; red = 1'b0; amber = 1'b0; green = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // Legal mode-0 then mode-1 streams, then blink and length faults
    for (int i = 0; i < 13; i++) begin
      drive_phase(tbl[i].lamp, tbl[i].len, tbl[i].variant);
      #1;
      chk($sformatf("v%0d_phase", i), phase, tbl[i].e_phase);
      chk($sformatf("v%0d_done_cnt", i), done_cnt, tbl[i].e_done);
      chk($sformatf("v%0d_len", i), phase_len, tbl[i].e_len);
      chk($sformatf("v%0d_errst", i), err_status, tbl[i].e_err);
      chk($sformatf("v%0d_mv", i), mode_valid, tbl[i].e_mv);
      chk($sformatf("v%0d_mode", i), mode, tbl[i].e_mode);
      chk($sformatf("v%0d_errp_cnt", i), errp_cnt, tbl[i].e_errp);
    end

    // RED followed directly by AMBER
    do_reset();
    drive_phase(3, 30, 0);
    drive_phase(1, 350, 0);
    drive_phase(3, 30, 0);
    idle(1);
    #1;
    chk("seq_errst", err_status, 1);
    chk("seq_errp_cnt", errp_cnt, 1);
    chk("seq_done_cnt", done_cnt, 0);
    chk("seq_phase", phase, 3);

    // RED and GREEN overlap after mode is confirmed
    do_reset();
    drive_phase(3, 30, 0);
    drive_phase(1, 350, 0);
    drive_phase(2, 350, 0);
    drive_phase(3, 30, 0);
    #1;
    chk("ovl_pre_mv", mode_valid, 1);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    idle(3);
    #1;
    chk("ovl_errst", err_status, 2);
    chk("ovl_phase", phase, 0);
    chk("ovl_mv", mode_valid, 0);
    chk("ovl_errp_cnt", errp_cnt, 1);

    // Two consecutive all-low cycles mid-phase
    do_reset();
    drive_phase(3, 30, 0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0);
    idle(4);
    #1;
    chk("dbl_errst", err_status, 4);
    chk("dbl_phase", phase, 0);
    chk("dbl_errp_cnt", errp_cnt, 1);

    // Reset mid-RED, then resynchronise
    do_reset();
    drive_phase(3, 30, 0);
    for (int p = 1; p <= 100; p++) step(1'b1, 1'b0, 1'b0);
    #1;
    chk("rst_pre_phase", phase, 1);
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int p = 101; p <= 350; p++)
      step((p != 348) && (p != 350), 1'b0, 1'b0);
    drive_phase(2, 350, 0);
    #1;
    chk("rst_green_phase", phase, 2);
    chk("rst_green_done_cnt", done_cnt, 0);
    drive_phase(3, 30, 0);
    #1;
    chk("rst_amber_done_cnt", done_cnt, 1);
    chk("rst_amber_len", phase_len, 350);
    chk("rst_amber_errst", err_status, 0);
    chk("rst_amber_phase", phase, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
